// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit driving the data-memory port.
// Ports: clk, reset (sync, active-low); core request
//   req_valid/req_ready/req_we/req_addr/req_wdata/req_rd;
//   memory mem_addr/mem_wdata/mem_wen/mem_rdata;
//   write-back wb_valid/wb_rd/wb_data; status busy, err.
// Optional one-entry load buffer: define LSU_LDBUF_EN.
module dmem_lsu #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 16,
  parameter int RD_LAT    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [2:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH =
    (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [2:0] LAT = 3'(RD_LAT);

  typedef enum logic [1:0] {
    IDLE, STORE, LOAD, WB
  } st_t;

  st_t st, st_nx;

  logic [2:0]        cnt;
  logic [2:0]        rd_q;
  logic              acc;
  logic              hit;
  logic              a_ok;
  logic              ld_done;
  logic [DATA_W-1:0] buf_d;

  // mem_addr doubles as the latched request address
  assign a_ok    = {1'b0, mem_addr} < DEPTH;
  assign acc     = req_valid & req_ready;
  assign ld_done = (st == LOAD) && (cnt == LAT);

`ifdef LSU_LDBUF_EN
  logic              buf_v;
  logic [ADDR_W-1:0] buf_tag;

  assign hit = ~req_we & buf_v
             & (req_addr == buf_tag);

  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_v   <= 1'b0;
      buf_tag <= '0;
      buf_d   <= '0;
    end else if (ld_done && a_ok) begin
      buf_v   <= 1'b1;
      buf_tag <= mem_addr;
      buf_d   <= mem_rdata;
    end else if (st == STORE && a_ok && buf_v
                 && mem_addr == buf_tag) begin
      buf_d <= mem_wdata;
    end
  end
`else
  assign hit   = 1'b0;
  assign buf_d = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) st <= IDLE;
    else        st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:
        if (acc) begin
          if (req_we)   st_nx = STORE;
          else if (hit) st_nx = WB;
          else          st_nx = LOAD;
        end
      STORE: st_nx = IDLE;
      LOAD:  if (cnt == LAT) st_nx = WB;
      WB:    st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    mem_wen   = 1'b0;
    wb_valid  = 1'b0;
    busy      = 1'b1;
    unique case (st)
      IDLE: begin
        req_ready = reset;
        busy      = 1'b0;
      end
      STORE: mem_wen  = a_ok & reset;
      WB:    wb_valid = reset;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_rd     <= '0;
      wb_data   <= '0;
      err       <= 1'b0;
      cnt       <= '0;
      rd_q      <= '0;
    end else begin
      // a buffer hit makes no memory access
      if (acc && !hit) begin
        mem_addr <= req_addr;
        rd_q     <= req_rd;
        if (req_we) mem_wdata <= req_wdata;
      end
      if (acc && hit) begin
        wb_rd   <= req_rd;
        wb_data <= buf_d;
      end
      cnt <= (st == LOAD) ? cnt + 3'd1 : 3'd0;
      if (st == STORE && !a_ok) err <= 1'b1;
      if (ld_done) begin
        wb_rd   <= rd_q;
        wb_data <= a_ok ? mem_rdata : '0;
        if (!a_ok) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed table, hand sequences and random
// transactions checked against a transaction-level model.
module tb_dmem_lsu;

  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [2:0]    req_rd = '0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wen;
  logic [DW-1:0] mem_rdata;
  logic          wb_valid;
  logic [2:0]    wb_rd;
  logic [DW-1:0] wb_data;
  logic          busy;
  logic          err;

  always #5 clk = ~clk;

  dmem_lsu #(
    .ADDR_W(AW), .DATA_W(DW),
    .MEM_DEPTH(DEPTH), .RD_LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wen(mem_wen), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .busy(busy), .err(err)
  );

  // memory: read data is only valid once the address
  // has been stable for LAT cycles
  logic [DW-1:0] bmem [DEPTH];
  logic [AW-1:0] last_a = '0;
  int            stable = 0;

  always @(negedge clk) begin
    last_a <= mem_addr;
    if (mem_addr !== last_a) stable <= 0;
    else if (stable < 100)   stable <= stable + 1;
  end

  always @(posedge clk)
    if (mem_wen) bmem[mem_addr[3:0]] <= mem_wdata;

  assign mem_rdata =
    (stable < LAT)            ? 16'hDEAD :
    (int'(mem_addr) < DEPTH)  ? bmem[mem_addr[3:0]] :
                                16'hBAD0;

  // reference model
  logic [DW-1:0] ref_mem [DEPTH];
  bit            exp_err = 1'b0;
`ifdef LSU_LDBUF_EN
  bit            bv = 1'b0;
  logic [AW-1:0] bt = '0;
`endif

  int total = 0;
  int bad = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // one request starting in IDLE between negedge and posedge;
  // returns at the negedge of the cycle where ready is back
  task automatic do_req(bit we, logic [AW-1:0] a,
                        logic [DW-1:0] d, logic [2:0] rd);
    bit ok;
    bit hit;
    int k;
    ok  = int'(a) < DEPTH;
    hit = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_rd    = rd;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
    req_rd    = 3'($urandom);
    if (we) begin
      chk("st_wen", mem_wen, ok);
      chk("st_busy", busy, 1);
      if (ok) begin
        chk("st_addr", mem_addr, a);
        chk("st_wdata", mem_wdata, d);
        ref_mem[a[3:0]] = d;
      end else begin
        exp_err = 1'b1;
      end
      @(negedge clk);
      chk("st_wen_off", mem_wen, 0);
    end else begin
`ifdef LSU_LDBUF_EN
      hit = bv && (bt == a);
`endif
      k = hit ? 1 : 2 + LAT;
      for (int c = 1; c < k; c++) begin
        chk("ld_wait", {mem_wen, wb_valid}, 0);
        chk("ld_addr", mem_addr, a);
        @(negedge clk);
      end
      chk("wb_valid", wb_valid, 1);
      chk("wb_rd", wb_rd, rd);
      chk("wb_data", wb_data,
          ok ? ref_mem[a[3:0]] : 16'h0);
      if (!ok) exp_err = 1'b1;
`ifdef LSU_LDBUF_EN
      if (ok) begin
        bv = 1'b1;
        bt = a;
      end
`endif
      @(negedge clk);
      chk("wb_off", wb_valid, 0);
      chk("wb_hold", wb_data,
          ok ? ref_mem[a[3:0]] : 16'h0);
    end
    chk("err", err, exp_err);
    chk("ready_after", req_ready, 1);
  endtask

  typedef struct {
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [2:0]    rd;
    logic [DW-1:0] exp_d;
    bit            exp_e;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] ra;
    int            wait_c;
    int            k;
    bit            hit;

    for (int i = 0; i < DEPTH; i++) begin
      logic [DW-1:0] v;
      v = DW'($urandom);
      if (i == 7) v = 16'h1234;
      if (i == 0) v = 16'h5A5A;
      bmem[i]    <= v;
      ref_mem[i] = v;
    end

    tbl = '{
      '{1, 5'd3,  16'hA5C3, 3'd0, 16'h0,    0},
      '{0, 5'd7,  16'h0,    3'd5, 16'h1234, 0},
      '{1, 5'd2,  16'h00FF, 3'd0, 16'h0,    0},
      '{0, 5'd2,  16'h0,    3'd1, 16'h00FF, 0},
      '{0, 5'd3,  16'h0,    3'd2, 16'hA5C3, 0},
      '{1, 5'd15, 16'hBEEF, 3'd0, 16'h0,    0},
      '{0, 5'd15, 16'h0,    3'd7, 16'hBEEF, 0},
      '{0, 5'd0,  16'h0,    3'd0, 16'h5A5A, 0},
      '{1, 5'd16, 16'h1111, 3'd0, 16'h0,    1},
      '{0, 5'd20, 16'h0,    3'd3, 16'h0,    1},
      '{0, 5'd3,  16'h0,    3'd4, 16'hA5C3, 1}
    };

    // reset held with a pending request
    reset     = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 5'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", req_ready, 0);
      chk("rst_wen", mem_wen, 0);
      chk("rst_wb", wb_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
    end
    reset     = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("rst_ready_up", req_ready, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wbdata", wb_data, 0);
    chk("rst_wbrd", wb_rd, 0);

    foreach (tbl[i]) begin
      do_req(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].rd);
      if (!tbl[i].we)
        chk("tbl_data", wb_data, tbl[i].exp_d);
      chk("tbl_err", err, tbl[i].exp_e);
    end

    // back-to-back: valid stays high across both requests
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 5'd2;
    req_wdata = 16'h00FF;
    @(negedge clk);
    chk("bb_wen", mem_wen, 1);
    chk("bb_ready_busy", req_ready, 0);
    ref_mem[2] = 16'h00FF;
    req_we = 1'b0;
    req_rd = 3'd1;
    @(negedge clk);
    chk("bb_ready", req_ready, 1);
    hit = 1'b0;
`ifdef LSU_LDBUF_EN
    hit = bv && (bt == 5'd2);
    bv  = 1'b1;
    bt  = 5'd2;
`endif
    k = hit ? 1 : 2 + LAT;
    wait_c = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (wb_valid && wait_c == 0) begin
        wait_c = c;
        chk("bb_data", wb_data, 16'h00FF);
        chk("bb_rd", wb_rd, 1);
      end
    end
    chk("bb_lat", wait_c, k);

    // two loads of the same address
    do_req(1'b0, 5'd4, 16'h0, 3'd2);
    do_req(1'b0, 5'd4, 16'h0, 3'd6);

    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 3) == 0) ra = req_addr;
      else ra = AW'($urandom_range(0, 19));
      do_req(1'($urandom), ra, DW'($urandom),
             3'($urandom));
    end

    // reset during the second LOAD cycle
    ra = 5'd5;
`ifdef LSU_LDBUF_EN
    if (bv && bt == ra) ra = 5'd6;
`endif
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = ra;
    req_rd    = 3'd6;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_busy", busy, 1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_wb", wb_valid, 0);
      chk("mid_busy_off", busy, 0);
      chk("mid_wen", mem_wen, 0);
      chk("mid_err", err, 0);
    end
    reset = 1'b1;
    exp_err = 1'b0;
`ifdef LSU_LDBUF_EN
    bv = 1'b0;
`endif
    #1;
    chk("mid_ready", req_ready, 1);
    do_req(1'b0, 5'd7, 16'h0, 3'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
